// File: rtl/egm_trial_sequencer.sv
// Evoked-response trial sequencer: waits out an inter-trial delay, raises stimulus,
// times the synchronized response edge, and reports per-trial latency or timeout.
module egm_trial_sequencer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic             clkin_50,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       num_trials,
    input  logic [CNT_W-1:0] delay_cycles,
    input  logic             response,
    output logic             stimulus,
    output logic             busy,
    output logic             result_valid,
    output logic [CNT_W-1:0] result_latency,
    output logic             result_timeout,
    output logic [7:0]       trial_idx,
    output logic [7:0]       timeout_count,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        STIM,
        REPORT,
        RELEASE,
        FINISH
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

    state_t           state_reg;
    logic             sync1_reg;
    logic             resp_s;
    logic             resp_d;
    logic             rise;
    logic [7:0]       n_trials_reg;
    logic [CNT_W-1:0] delay_reg;
    logic [CNT_W-1:0] delay_cnt_reg;
    logic [CNT_W-1:0] lat_cnt_reg;

    always_ff @(posedge clkin_50 or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            resp_s    <= 1'b0;
            resp_d    <= 1'b0;
        end else begin
            sync1_reg <= response;
            resp_s    <= sync1_reg;
            resp_d    <= resp_s;
        end
    end

    assign rise = resp_s & ~resp_d;
    assign busy = (state_reg != IDLE);

    always_ff @(posedge clkin_50 or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            stimulus       <= 1'b0;
            result_valid   <= 1'b0;
            result_latency <= '0;
            result_timeout <= 1'b0;
            trial_idx      <= 8'd0;
            timeout_count  <= 8'd0;
            done           <= 1'b0;
            n_trials_reg   <= 8'd0;
            delay_reg      <= '0;
            delay_cnt_reg  <= '0;
            lat_cnt_reg    <= '0;
        end else begin
            result_valid <= 1'b0;
            done         <= 1'b0;
            if (state_reg != IDLE && abort) begin
                // Cancel outright; result and counter outputs keep their last values.
                state_reg <= IDLE;
                stimulus  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            n_trials_reg  <= num_trials;
                            delay_reg     <= delay_cycles;
                            delay_cnt_reg <= delay_cycles;
                            trial_idx     <= 8'd0;
                            timeout_count <= 8'd0;
                            state_reg     <= (num_trials == 8'd0) ? FINISH : WAIT;
                        end
                    end
                    WAIT: begin
                        if (delay_cnt_reg != '0) begin
                            delay_cnt_reg <= delay_cnt_reg - 1'b1;
                        end else if (!resp_s) begin
                            state_reg   <= STIM;
                            stimulus    <= 1'b1;
                            lat_cnt_reg <= '0;
                        end
                    end
                    STIM: begin
                        // A response edge wins over a timeout landing in the same cycle.
                        if (rise) begin
                            result_latency <= lat_cnt_reg;
                            result_timeout <= 1'b0;
                            result_valid   <= 1'b1;
                            stimulus       <= 1'b0;
                            state_reg      <= REPORT;
                        end else if (lat_cnt_reg == TO_LAST) begin
                            result_latency <= TO_VAL;
                            result_timeout <= 1'b1;
                            result_valid   <= 1'b1;
                            stimulus       <= 1'b0;
                            if (timeout_count != 8'hFF)
                                timeout_count <= timeout_count + 8'd1;
                            state_reg      <= REPORT;
                        end else begin
                            lat_cnt_reg <= lat_cnt_reg + 1'b1;
                        end
                    end
                    REPORT: begin
                        if (trial_idx == n_trials_reg - 8'd1) begin
                            state_reg <= FINISH;
                        end else begin
                            trial_idx <= trial_idx + 8'd1;
                            state_reg <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (!resp_s) begin
                            delay_cnt_reg <= delay_reg;
                            state_reg     <= WAIT;
                        end
                    end
                    FINISH: begin
                        done      <= 1'b1;
                        state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule
